// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared state type, lane geometry and lane-search helper for the
// Wishbone-to-SRAM responder.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int          NUM_LANES    = 4;
    localparam int          LANE_W       = 8;
    localparam logic [31:0] STATS_OFFSET = 32'h0000_0400;

    typedef struct packed {
        logic       valid;
        logic [1:0] lane;
    } lane_pick_t;

    // Lowest set lane at or above start_lane; valid=0 when no selected lane remains.
    function automatic lane_pick_t first_lane(input logic [NUM_LANES-1:0] sel,
                                              input logic [2:0]           start_lane);
        lane_pick_t pick;
        pick = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (sel[i] && (i >= int'(start_lane))) begin
                pick.valid = 1'b1;
                pick.lane  = 2'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_sram_lane_seq.sv
// wb_sram_lane_seq: holds the accepted request, walks the selected byte lanes
// (skipping unselected ones) and owns the registered SRAM macro pins.
module wb_sram_lane_seq
    import wb_sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NUM_LANES-1:0] sel_new,
    input  logic [AW-3:0]        word_new,
    input  logic                 we_new,
    input  logic [31:0]          dat_new,
    input  logic                 step,
    input  logic                 issue_en,
    output logic                 first_valid,
    output logic                 next_valid,
    output logic [1:0]           lane,
    output logic                 we,
    output logic                 cen_n,
    output logic                 gwen_n,
    output logic [AW-1:0]        addr,
    output logic [LANE_W-1:0]    din
);

    lane_pick_t           first_pick;
    lane_pick_t           next_pick;
    logic [NUM_LANES-1:0] sel_q;
    logic [AW-3:0]        word_q;
    logic                 we_q;
    logic [31:0]          dat_q;
    logic [1:0]           lane_q;
    logic [1:0]           lane_nxt;
    logic [AW-3:0]        word_nxt;
    logic                 we_nxt;
    logic [31:0]          dat_nxt;

    // Lane search and the request view for the access about to be issued; on load
    // the fresh bus values are used since the holding registers update on the same edge.
    always_comb begin
        first_pick = first_lane(sel_new, 3'd0);
        next_pick  = first_lane(sel_q, {1'b0, lane_q} + 3'd1);
        lane_nxt   = lane_q;
        word_nxt   = word_q;
        we_nxt     = we_q;
        dat_nxt    = dat_q;
        if (load) begin
            lane_nxt = first_pick.lane;
            word_nxt = word_new;
            we_nxt   = we_new;
            dat_nxt  = dat_new;
        end else if (step) begin
            lane_nxt = next_pick.lane;
        end
    end

    assign first_valid = first_pick.valid;
    assign next_valid  = next_pick.valid;
    assign lane        = lane_q;
    assign we          = we_q;

    // Request holding registers and lane pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            word_q <= '0;
            we_q   <= 1'b0;
            dat_q  <= '0;
            lane_q <= '0;
        end else begin
            if (load) begin
                sel_q <= sel_new;
            end
            word_q <= word_nxt;
            we_q   <= we_nxt;
            dat_q  <= dat_nxt;
            lane_q <= lane_nxt;
        end
    end

    // Macro pins: enabled only for cycles spent in ISSUE; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_n  <= 1'b1;
            gwen_n <= 1'b1;
            addr   <= '0;
            din    <= '0;
        end else if (issue_en) begin
            cen_n  <= 1'b0;
            gwen_n <= ~we_nxt;
            addr   <= {word_nxt, lane_nxt};
            din    <= dat_nxt[{lane_nxt, 3'b000} +: LANE_W];
        end else begin
            cen_n  <= 1'b1;
            gwen_n <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_sram_responder.sv
// wb_sram_responder: Wishbone classic responder bridging 32-bit word accesses onto
// a 1024x8 SRAM macro, one SRAM access per selected byte lane, then one ack pulse.
// Build macro SRAM_WB_STATS_EN adds a 32-bit transfer counter at BASE_ADDR+0x400.
//
// state | meaning
// IDLE  | waiting for a window (or counter) hit; request latched on accept
// ISSUE | current selected lane is driven onto the macro pins
// CAPT  | read data for the current lane returns and is captured into dat_o
// ACK   | single-cycle acknowledge, then back to IDLE
module wb_sram_responder
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SRAM_AW   = 10
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               sram_cen_n,
    output logic               sram_gwen_n,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_din,
    input  logic [7:0]         sram_dout
);

    state_t      state_q;
    state_t      state_nxt;
    logic        win_hit;
    logic        stats_hit;
    logic        accept;
    logic        load;
    logic        step;
    logic        capture;
    logic        rd_clear;
    logic        stats_rd;
    logic        issue_en;
    logic        first_valid;
    logic        next_valid;
    logic        lane_we;
    logic [1:0]  lane;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] stats_val;
    logic        unused_adr;

    assign win_hit    = wbs_cyc_i & wbs_stb_i &
                        (wbs_adr_i[31:SRAM_AW] == BASE_ADDR[31:SRAM_AW]);
    assign accept     = (state_q == IDLE) && (win_hit || stats_hit);
    assign unused_adr = ^wbs_adr_i[1:0];

`ifdef SRAM_WB_STATS_EN
    localparam logic [31:0] STATS_ADDR = BASE_ADDR + STATS_OFFSET;

    logic        stats_q;
    logic [31:0] cnt_q;

    assign stats_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:2] == STATS_ADDR[31:2]);
    assign stats_val = cnt_q;

    // Transfer counter: a counter write clears it, each acked window transfer bumps it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stats_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                stats_q <= stats_hit;
            end
            if (accept && stats_hit && wbs_we_i) begin
                cnt_q <= '0;
            end else if (ack_q && !stats_q) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end
`else
    assign stats_hit = 1'b0;
    assign stats_val = '0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and per-cycle control; dropping cyc abandons the transfer without ack.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        rd_clear  = 1'b0;
        stats_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_hit) begin
                    load      = 1'b1;
                    rd_clear  = ~wbs_we_i;
                    state_nxt = first_valid ? ISSUE : ACK;
                end else if (stats_hit) begin
                    stats_rd  = ~wbs_we_i;
                    state_nxt = ACK;
                end
            end
            ISSUE: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (!lane_we) begin
                    state_nxt = CAPT;
                end else if (next_valid) begin
                    step      = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = ACK;
                end
            end
            CAPT: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else begin
                    capture = 1'b1;
                    if (next_valid) begin
                        step      = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign issue_en = (state_nxt == ISSUE);

    wb_sram_lane_seq #(
        .AW (SRAM_AW)
    ) u_lane_seq (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .load        (load),
        .sel_new     (wbs_sel_i),
        .word_new    (wbs_adr_i[SRAM_AW-1:2]),
        .we_new      (wbs_we_i),
        .dat_new     (wbs_dat_i),
        .step        (step),
        .issue_en    (issue_en),
        .first_valid (first_valid),
        .next_valid  (next_valid),
        .lane        (lane),
        .we          (lane_we),
        .cen_n       (sram_cen_n),
        .gwen_n      (sram_gwen_n),
        .addr        (sram_addr),
        .din         (sram_din)
    );

    // Ack pulse and read-data assembly; dat_o keeps its value after the ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= (state_nxt == ACK);
            if (rd_clear) begin
                dat_q <= '0;
            end else if (stats_rd) begin
                dat_q <= stats_val;
            end else if (capture) begin
                dat_q[{lane, 3'b000} +: LANE_W] <= sram_dout;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// tb_wb_sram_responder: directed bench for wb_sram_responder with a behavioural
// SRAM macro, a byte-array reference memory and per-cycle access checking.
module tb_wb_sram_responder;

    localparam logic [31:0] BASE       = 32'h3000_0000;
    localparam logic [31:0] STATS_WORD = BASE + 32'h0000_0400;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_cen_n;
    logic        sram_gwen_n;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout = 8'h00;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_sram_responder #(
        .BASE_ADDR (BASE),
        .SRAM_AW   (10)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .sram_cen_n  (sram_cen_n),
        .sram_gwen_n (sram_gwen_n),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout)
    );

    // Behavioural macro: one access per enabled cycle, read data valid the cycle after.
    logic [7:0] sram_mem [0:1023];
    always @(posedge wb_clk_i) begin
        if (!sram_cen_n) begin
            if (!sram_gwen_n) sram_mem[sram_addr] <= sram_din;
            else              sram_dout <= sram_mem[sram_addr];
        end
    end

    typedef struct packed {
        logic [9:0] addr;
        logic       we;
        logic [7:0] din;
    } acc_t;

    acc_t        exp_acc_q[$];
    logic [7:0]  ref_mem [0:1023];
    int unsigned model_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic [9:0]  last_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock; any macro access seen this cycle must be the next one the model expects.
    task automatic step_cycle();
        acc_t e;
        @(negedge wb_clk_i);
        if (!sram_cen_n) begin
            n_acc++;
            last_addr = sram_addr;
            if (exp_acc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access: got access at addr %h expected none", sram_addr);
            end else begin
                e = exp_acc_q.pop_front();
                check("acc_addr", 32'(sram_addr), 32'(e.addr));
                check("acc_we", 32'(!sram_gwen_n), 32'(e.we));
                if (e.we) check("acc_din", 32'(sram_din), 32'(e.din));
            end
        end
    endtask

    // Full transfer: model predicts accesses, latency and read data, then drives the bus.
    task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdata, output int lat);
        logic [31:0] exp_rd;
        logic [9:0]  a;
        int          exp_lat;
        int          k;
        bit          is_stats;
        bit          acked;
        exp_rd   = '0;
        k        = 0;
        is_stats = 1'b0;
        acked    = 1'b0;
        lat      = 0;
`ifdef SRAM_WB_STATS_EN
        is_stats = ((adr & ~32'h3) == STATS_WORD);
`endif
        if (is_stats) begin
            exp_lat = 1;
            if (we) model_cnt = 0;
            else    exp_rd = 32'(model_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    a = {adr[9:2], 2'(i)};
                    k++;
                    if (we) begin
                        exp_acc_q.push_back(acc_t'({a, 1'b1, dat[8*i +: 8]}));
                        ref_mem[a] = dat[8*i +: 8];
                    end else begin
                        exp_acc_q.push_back(acc_t'({a, 1'b0, 8'h00}));
                        exp_rd[8*i +: 8] = ref_mem[a];
                    end
                end
            end
            exp_lat = (k == 0) ? 1 : (we ? k + 1 : 2 * k + 1);
            model_cnt++;
        end
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        for (int c = 1; c <= 40 && !acked; c++) begin
            step_cycle();
            if (wbs_ack_o) begin
                acked = 1'b1;
                lat   = c;
            end
        end
        rdata     = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check("ack_seen", 32'(acked), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        if (!we) check("read_data", rdata, exp_rd);
        check("acc_left", 32'(exp_acc_q.size()), 32'd0);
        exp_acc_q.delete();
        step_cycle();
    endtask

    task automatic do_miss(input logic [31:0] adr, input logic we);
        int acks;
        acks      = 0;
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_sel_i = 4'hF;
        wbs_dat_i = 32'h1234_5678;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        repeat (12) begin
            step_cycle();
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check("miss_no_ack", 32'(acks), 32'd0);
        step_cycle();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          acc0;

        repeat (3) @(negedge wb_clk_i);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_cen_n", 32'(sram_cen_n), 32'd1);
        check("rst_gwen_n", 32'(sram_gwen_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_din", 32'(sram_din), 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Full word write and readback.
        do_xfer(BASE + 32'h10, 1'b1, 4'hF, 32'hA1B2_C3D4, rd, lat);
        check("wr_full_lat", 32'(lat), 32'd5);
        do_xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd, lat);
        check("rd_full_lat", 32'(lat), 32'd9);
        check("rd_full_data", rd, 32'hA1B2_C3D4);

        // Single-lane write into a known word.
        do_xfer(BASE + 32'h20, 1'b1, 4'hF, 32'h1122_3344, rd, lat);
        acc0 = n_acc;
        do_xfer(BASE + 32'h20, 1'b1, 4'b0100, 32'h00EE_0000, rd, lat);
        check("one_lane_count", 32'(n_acc - acc0), 32'd1);
        check("one_lane_addr", 32'(last_addr), 32'h22);
        check("one_lane_lat", 32'(lat), 32'd2);
        do_xfer(BASE + 32'h20, 1'b0, 4'hF, 32'h0, rd, lat);
        check("one_lane_rb", rd, 32'h11EE_3344);

        // Miss outside the window; empty byte-select transfers.
        do_miss(32'h3000_0800, 1'b0);
        acc0 = n_acc;
        do_xfer(BASE, 1'b1, 4'b0000, 32'hFFFF_FFFF, rd, lat);
        check("sel0_lat", 32'(lat), 32'd1);
        check("sel0_no_access", 32'(n_acc - acc0), 32'd0);
        do_xfer(BASE, 1'b0, 4'b0000, 32'h0, rd, lat);
        check("sel0_rd_data", rd, 32'h0);

        // Sparse read: unselected lanes return zero.
        do_xfer(BASE + 32'h10, 1'b0, 4'b1010, 32'h0, rd, lat);
        check("sparse_lat", 32'(lat), 32'd5);
        check("sparse_data", rd, 32'hA100_C300);

        // cyc dropped after the second lane of a full-word write.
        do_xfer(BASE + 32'h30, 1'b1, 4'hF, 32'hCAFE_F00D, rd, lat);
        exp_acc_q.push_back(acc_t'({10'h30, 1'b1, 8'h88}));
        exp_acc_q.push_back(acc_t'({10'h31, 1'b1, 8'h77}));
        ref_mem[10'h30] = 8'h88;
        ref_mem[10'h31] = 8'h77;
        wbs_adr_i = BASE + 32'h30;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_dat_i = 32'h5566_7788;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        step_cycle();
        step_cycle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        step_cycle();
        check("abort_cen_n", 32'(sram_cen_n), 32'd1);
        check("abort_ack", 32'(wbs_ack_o), 32'd0);
        check("abort_acc_left", 32'(exp_acc_q.size()), 32'd0);
        exp_acc_q.delete();
        do_xfer(BASE, 1'b0, 4'b0000, 32'h0, rd, lat);
        check("abort_then_idle_lat", 32'(lat), 32'd1);
        do_xfer(BASE + 32'h30, 1'b0, 4'hF, 32'h0, rd, lat);
        check("abort_rb", rd, 32'hCAFE_7788);

        // Reset asserted in the middle of a read.
        exp_acc_q.push_back(acc_t'({10'h10, 1'b0, 8'h00}));
        exp_acc_q.push_back(acc_t'({10'h11, 1'b0, 8'h00}));
        wbs_adr_i = BASE + 32'h10;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        repeat (3) step_cycle();
        wb_rst_i = 1'b1;
        step_cycle();
        check("midrst_cen_n", 32'(sram_cen_n), 32'd1);
        check("midrst_ack", 32'(wbs_ack_o), 32'd0);
        check("midrst_dat", wbs_dat_o, 32'd0);
        wb_rst_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        step_cycle();
        check("midrst_acc_left", 32'(exp_acc_q.size()), 32'd0);
        exp_acc_q.delete();
        model_cnt = 0;

        // Top word of the window.
        do_xfer(BASE + 32'h3FC, 1'b1, 4'hF, 32'hDEAD_BEEF, rd, lat);
        check("top_last_addr", 32'(last_addr), 32'h3FF);
        do_xfer(BASE + 32'h3FC, 1'b0, 4'hF, 32'h0, rd, lat);
        check("top_rb", rd, 32'hDEAD_BEEF);

        // stb held through ack: one idle cycle, then the next transfer is accepted.
        wbs_adr_i = BASE;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'b0000;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        step_cycle();
        check("b2b_ack1", 32'(wbs_ack_o), 32'd1);
        step_cycle();
        check("b2b_gap", 32'(wbs_ack_o), 32'd0);
        step_cycle();
        check("b2b_ack2", 32'(wbs_ack_o), 32'd1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        step_cycle();
        model_cnt = model_cnt + 2;

`ifdef SRAM_WB_STATS_EN
        do_xfer(STATS_WORD, 1'b0, 4'hF, 32'h0, rd, lat);
        do_xfer(STATS_WORD, 1'b1, 4'h1, 32'h0, rd, lat);
        check("stats_clr_lat", 32'(lat), 32'd1);
        do_xfer(BASE + 32'h40, 1'b1, 4'hF, 32'h0102_0304, rd, lat);
        do_xfer(BASE + 32'h40, 1'b0, 4'hF, 32'h0, rd, lat);
        do_xfer(BASE, 1'b1, 4'b0000, 32'h0, rd, lat);
        do_xfer(STATS_WORD, 1'b0, 4'hF, 32'h0, rd, lat);
        check("stats_three", rd, 32'd3);
        do_xfer(STATS_WORD, 1'b1, 4'hF, 32'h0, rd, lat);
        do_xfer(STATS_WORD, 1'b0, 4'hF, 32'h0, rd, lat);
        check("stats_cleared", rd, 32'd0);
`else
        do_miss(STATS_WORD, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
